// File: rtl/alu_rsv_station.sv
// Age-ordered, compacting reservation station for the integer ALU.
// It captures CDB operands and issues the oldest entry whose two sources are both ready.
module alu_rsv_station #(
   parameter int BW    = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         disp_valid,
   output logic                         disp_ready,
   input  logic [3:0]                   disp_choice,
   input  logic [TAG_W-1:0]             disp_dest,
   input  logic                         disp_s1_rdy,
   input  logic [TAG_W-1:0]             disp_s1_tag,
   input  logic [BW-1:0]                disp_s1_val,
   input  logic                         disp_s2_rdy,
   input  logic [TAG_W-1:0]             disp_s2_tag,
   input  logic [BW-1:0]                disp_s2_val,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   input  logic [BW-1:0]                cdb_data,
   output logic                         iss_valid,
   input  logic                         iss_ready,
   output logic [BW-1:0]                iss_d1,
   output logic [BW-1:0]                iss_d2,
   output logic [3:0]                   iss_choice,
   output logic [TAG_W-1:0]             iss_dest,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef struct packed {
      logic             s1_rdy;
      logic [TAG_W-1:0] s1_tag;
      logic [BW-1:0]    s1_val;
      logic             s2_rdy;
      logic [TAG_W-1:0] s2_tag;
      logic [BW-1:0]    s2_val;
      logic [3:0]       choice;
      logic [TAG_W-1:0] dest;
   } entry_t;

   entry_t          ent_q [DEPTH];
   entry_t          ent_d [DEPTH];
   entry_t          woken [DEPTH];
   entry_t          disp_e;
   logic            sel_found;
   logic [IW-1:0]   sel_idx;
   logic            issue_fire;
   logic            disp_fire;
   logic [CW-1:0]   tail;
   logic [CW-1:0]   count_d;

   // A waiting source whose tag matches a valid broadcast takes the broadcast value.
   function automatic entry_t wake(entry_t e, logic cv, logic [TAG_W-1:0] ct, logic [BW-1:0] cd);
      entry_t r;
      r = e;
      if (cv && !r.s1_rdy && r.s1_tag == ct) begin
         r.s1_rdy = 1'b1;
         r.s1_val = cd;
      end
      if (cv && !r.s2_rdy && r.s2_tag == ct) begin
         r.s2_rdy = 1'b1;
         r.s2_val = cd;
      end
      return r;
   endfunction

   assign disp_ready = (count < DEPTH_C);
   assign disp_fire  = disp_valid && disp_ready;
   assign issue_fire = sel_found && iss_ready;
   assign tail       = count - CW'(issue_fire);
   assign count_d    = count + CW'(disp_fire) - CW'(issue_fire);

   // Selection looks only at registered readiness, so a wakeup becomes issuable one cycle later.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (CW'(i) < count && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
            sel_found = 1'b1;
            sel_idx   = IW'(i);
         end
      end
   end

   assign iss_valid  = sel_found;
   assign iss_d1     = ent_q[sel_idx].s1_val;
   assign iss_d2     = ent_q[sel_idx].s2_val;
   assign iss_choice = ent_q[sel_idx].choice;
   assign iss_dest   = ent_q[sel_idx].dest;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         woken[i] = wake(ent_q[i], cdb_valid, cdb_tag, cdb_data);
      end
   end

   always_comb begin
      disp_e.s1_rdy = disp_s1_rdy;
      disp_e.s1_tag = disp_s1_tag;
      disp_e.s1_val = disp_s1_val;
      disp_e.s2_rdy = disp_s2_rdy;
      disp_e.s2_tag = disp_s2_tag;
      disp_e.s2_val = disp_s2_val;
      disp_e.choice = disp_choice;
      disp_e.dest   = disp_dest;
      disp_e        = wake(disp_e, cdb_valid, cdb_tag, cdb_data);
   end

   // Compaction: entries above the issued one move down a slot, carrying any value captured this cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = woken[i];
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (issue_fire && i >= int'(sel_idx)) ent_d[i] = woken[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (disp_fire && CW'(i) == tail) ent_d[i] = disp_e;
      end
   end

   // NOTE: sequential state is assigned with non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset || flush) count <= '0;
      else                count <= count_d;
   end

   // NOTE: the entry array has no reset; validity comes from count alone, so stale contents are harmless.
   always_ff @(posedge clock) begin
      if (!flush) ent_q <= ent_d;
   end

endmodule

// File: tb/tb_alu_rsv_station.sv
// Scoreboard bench for alu_rsv_station: expected issues are queued as stimulus is driven
// and compared when an issue handshake happens.
module tb_alu_rsv_station;

   localparam int BW = 32;
   localparam int DEPTH = 4;
   localparam int TAG_W = 6;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;

   logic             clock, reset, flush;
   logic             disp_valid, disp_ready;
   logic [3:0]       disp_choice;
   logic [TAG_W-1:0] disp_dest, disp_s1_tag, disp_s2_tag;
   logic             disp_s1_rdy, disp_s2_rdy;
   logic [BW-1:0]    disp_s1_val, disp_s2_val;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [BW-1:0]    cdb_data;
   logic             iss_valid, iss_ready;
   logic [BW-1:0]    iss_d1, iss_d2;
   logic [3:0]       iss_choice;
   logic [TAG_W-1:0] iss_dest;
   logic [2:0]       count;

   int tests = 0;
   int fails = 0;
   logic [73:0] sb[$];

   alu_rsv_station #(.BW(BW), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_choice(disp_choice), .disp_dest(disp_dest),
      .disp_s1_rdy(disp_s1_rdy), .disp_s1_tag(disp_s1_tag), .disp_s1_val(disp_s1_val),
      .disp_s2_rdy(disp_s2_rdy), .disp_s2_tag(disp_s2_tag), .disp_s2_val(disp_s2_val),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_d1(iss_d1), .iss_d2(iss_d2), .iss_choice(iss_choice), .iss_dest(iss_dest),
      .count(count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [73:0] mk(logic [31:0] d1, logic [31:0] d2, logic [3:0] ch, logic [5:0] dest);
      return {d1, d2, ch, dest};
   endfunction

   // Scoreboard: every accepted issue is compared with the oldest outstanding expectation.
   always @(negedge clock) begin
      if (!reset && !flush && iss_valid && iss_ready) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 96'(sb.size()), 96'd1);
         end else begin
            check("issue", 96'({iss_d1, iss_d2, iss_choice, iss_dest}), 96'(sb.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic disp(input logic [3:0] ch, input logic [5:0] dest,
                       input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                       input logic r2, input logic [5:0] t2, input logic [31:0] v2);
      disp_valid  = 1'b1;
      disp_choice = ch;
      disp_dest   = dest;
      disp_s1_rdy = r1;
      disp_s1_tag = t1;
      disp_s1_val = v1;
      disp_s2_rdy = r2;
      disp_s2_tag = t2;
      disp_s2_val = v2;
   endtask

   task automatic cdb(input logic [5:0] t, input logic [31:0] d);
      cdb_valid = 1'b1;
      cdb_tag   = t;
      cdb_data  = d;
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 40 && count != 0; n++) tick();
      check({tag, "_count"}, 96'(count), 96'd0);
      check({tag, "_sb_left"}, 96'(sb.size()), 96'd0);
   endtask

   task automatic build_three();
      disp(ALU_OR, 6'd40, 1'b0, 6'd20, 32'h0, 1'b0, 6'd20, 32'h0);
      tick();
      disp(ALU_ADD, 6'd41, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
      tick();
      disp(ALU_SUB, 6'd42, 1'b0, 6'd21, 32'h0, 1'b1, 6'd0, 32'd5);
      tick();
      disp_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0; cdb_valid = 1'b0;
      disp_choice = '0; disp_dest = '0;
      disp_s1_rdy = 1'b0; disp_s1_tag = '0; disp_s1_val = '0;
      disp_s2_rdy = 1'b0; disp_s2_tag = '0; disp_s2_val = '0;
      cdb_tag = '0; cdb_data = '0;

      // Reset
      repeat (3) tick();
      reset = 1'b0;
      check("rst_count", 96'(count), 96'd0);
      check("rst_iss_valid", 96'(iss_valid), 96'd0);
      check("rst_disp_ready", 96'(disp_ready), 96'd1);

      // Single ready op passes straight through
      iss_ready = 1'b1;
      sb.push_back(mk(32'd5, 32'd7, ALU_ADD, 6'd3));
      disp(ALU_ADD, 6'd3, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
      tick();
      disp_valid = 1'b0;
      check("t2_iss_valid", 96'(iss_valid), 96'd1);
      check("t2_d1", 96'(iss_d1), 96'd5);
      check("t2_d2", 96'(iss_d2), 96'd7);
      check("t2_dest", 96'(iss_dest), 96'd3);
      tick();
      check("t2_count", 96'(count), 96'd0);

      // Fill, overflow drop, wakeup of the oldest
      iss_ready = 1'b0;
      disp(ALU_SUB, 6'd10, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'd2);
      tick();
      disp(ALU_AND, 6'd11, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4);
      tick();
      disp(ALU_OR, 6'd12, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd6);
      tick();
      disp(ALU_XOR, 6'd13, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 32'd8);
      tick();
      disp(ALU_ADD, 6'd14, 1'b1, 6'd0, 32'd99, 1'b1, 6'd0, 32'd99);
      check("t3_full_count", 96'(count), 96'd4);
      check("t3_disp_ready", 96'(disp_ready), 96'd0);
      tick();
      disp_valid = 1'b0;
      check("t3_drop_count", 96'(count), 96'd4);
      check("t3_sel_younger", 96'(iss_dest), 96'd11);
      cdb(6'd9, 32'h10);
      check("t3_no_same_cycle", 96'(iss_dest), 96'd11);
      tick();
      cdb_valid = 1'b0;
      check("t3_oldest_dest", 96'(iss_dest), 96'd10);
      check("t3_oldest_d1", 96'(iss_d1), 96'h10);
      sb.push_back(mk(32'h10, 32'd2, ALU_SUB, 6'd10));
      sb.push_back(mk(32'd3, 32'd4, ALU_AND, 6'd11));
      sb.push_back(mk(32'd5, 32'd6, ALU_OR, 6'd12));
      sb.push_back(mk(32'd7, 32'd8, ALU_XOR, 6'd13));
      iss_ready = 1'b1;
      drain("t3");

      // Younger ready ops bypass a waiting oldest one; dispatch and issue share an edge
      sb.push_back(mk(32'h0B, 32'd1, ALU_ADD, 6'd21));
      sb.push_back(mk(32'h0C, 32'd2, ALU_SUB, 6'd22));
      sb.push_back(mk(32'h44, 32'd3, ALU_AND, 6'd20));
      disp(ALU_AND, 6'd20, 1'b0, 6'd4, 32'h0, 1'b1, 6'd0, 32'd3);
      tick();
      disp(ALU_ADD, 6'd21, 1'b1, 6'd0, 32'h0B, 1'b1, 6'd0, 32'd1);
      tick();
      check("t4_sel_b", 96'(iss_dest), 96'd21);
      disp(ALU_SUB, 6'd22, 1'b1, 6'd0, 32'h0C, 1'b1, 6'd0, 32'd2);
      tick();
      disp_valid = 1'b0;
      check("t4_count_after_b", 96'(count), 96'd2);
      check("t4_sel_c", 96'(iss_dest), 96'd22);
      tick();
      check("t4_count_a_only", 96'(count), 96'd1);
      check("t4_a_waiting", 96'(iss_valid), 96'd0);
      cdb(6'd4, 32'h44);
      tick();
      cdb_valid = 1'b0;
      check("t4_a_ready", 96'(iss_valid), 96'd1);
      drain("t4");

      // Dispatch bypass from the CDB
      iss_ready = 1'b0;
      disp(ALU_ADD, 6'd30, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'd9);
      cdb(6'd12, 32'hDEAD);
      tick();
      disp_valid = 1'b0;
      cdb_valid  = 1'b0;
      check("t5_iss_valid", 96'(iss_valid), 96'd1);
      check("t5_d1", 96'(iss_d1), 96'hDEAD);
      sb.push_back(mk(32'hDEAD, 32'd9, ALU_ADD, 6'd30));
      iss_ready = 1'b1;
      drain("t5");

      // Flush beats simultaneous dispatch and issue
      iss_ready = 1'b0;
      build_three();
      check("t6_count3", 96'(count), 96'd3);
      check("t6_sel_e1", 96'(iss_dest), 96'd41);
      disp(ALU_XOR, 6'd43, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 32'd7);
      iss_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      disp_valid = 1'b0;
      iss_ready = 1'b0;
      check("t6_flush_count", 96'(count), 96'd0);
      check("t6_flush_iss", 96'(iss_valid), 96'd0);
      check("t6_flush_ready", 96'(disp_ready), 96'd1);

      // Same again without flush: middle entry leaves, age order kept
      build_three();
      sb.push_back(mk(32'd1, 32'd2, ALU_ADD, 6'd41));
      disp(ALU_XOR, 6'd43, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 32'd7);
      iss_ready = 1'b1;
      tick();
      disp_valid = 1'b0;
      iss_ready = 1'b0;
      check("t6_count_kept", 96'(count), 96'd3);
      check("t6_sel_d", 96'(iss_dest), 96'd43);
      cdb(6'd21, 32'h2121);
      tick();
      cdb_valid = 1'b0;
      check("t6_sel_e2", 96'(iss_dest), 96'd42);
      cdb(6'd20, 32'h2020);
      tick();
      cdb_valid = 1'b0;
      check("t6_sel_e0", 96'(iss_dest), 96'd40);
      check("t6_both_woke", 96'(iss_d2), 96'h2020);
      sb.push_back(mk(32'h2020, 32'h2020, ALU_OR, 6'd40));
      sb.push_back(mk(32'h2121, 32'd5, ALU_SUB, 6'd42));
      sb.push_back(mk(32'd6, 32'd7, ALU_XOR, 6'd43));
      iss_ready = 1'b1;
      drain("t6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
